// File: rtl/ipsxe_floating_point_addsub_result_buf_if.sv
// Result stream interface for the add/sub result buffer.
// Carries one buffered result beat plus its {invalid_op, overflow, underflow} tag.
interface ipsxe_floating_point_addsub_result_buf_if #(
    parameter int W = 32
);
    logic [W-1:0] tdata;
    logic [2:0]   tuser;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tuser, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface

// File: rtl/ipsxe_floating_point_addsub_result_buf.sv
// Result buffer for the floating-point add/sub core.
// Show-ahead FIFO on the core's result stream, issue-credit tracking so the core
// never produces a result without room, sticky exception flags and an error flag.
// Optional: define ADDSUB_RESULT_STATS_EN for 16-bit saturating per-flag counters.
module ipsxe_floating_point_addsub_result_buf #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          i_aclk,
    input  logic          i_rst_n,
    input  logic          i_aclken,
    input  logic          i_issue,
    output logic          o_issue_ready,
    input  logic [W-1:0]  i_axis_result_tdata,
    input  logic          i_axis_result_tvalid,
    input  logic          i_invalid_op,
    input  logic          i_overflow,
    input  logic          i_underflow,
    ipsxe_floating_point_addsub_result_buf_if.master m_axis,
    input  logic          i_sticky_clr,
    output logic [2:0]    o_sticky_flags,
    output logic          o_buf_err
`ifdef ADDSUB_RESULT_STATS_EN
    ,
    output logic [15:0]   o_cnt_invalid,
    output logic [15:0]   o_cnt_overflow,
    output logic [15:0]   o_cnt_underflow
`endif
);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    // Entry layout: {tuser[2:0], tdata[W-1:0]}
    logic [W+2:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt, inflight;
    logic [2:0]    in_tuser;
    logic          push, pop, full, empty, accept, err_set;
    logic [AW+1:0] credit_sum;

    assign in_tuser = {i_invalid_op, i_overflow, i_underflow};
    assign empty    = (cnt == '0);
    assign full     = (cnt == DEPTH_C);
    assign push     = i_axis_result_tvalid;
    assign pop      = ~empty & m_axis.tready;
    // When full, a push only fits if the head leaves on the same edge.
    assign accept   = push & (~full | pop);
    // Error on a dropped beat, or on a result nobody issued (inflight would go negative).
    assign err_set  = (push & ~accept) | (accept & ~i_issue & (inflight == '0));

    // Credit is what remains after buffered and outstanding results are reserved.
    assign credit_sum    = {1'b0, cnt} + {1'b0, inflight};
    assign o_issue_ready = (credit_sum < DEPTH_W);

    // Show-ahead head; forced to zero while empty so the idle bus is clean.
    assign m_axis.tvalid = ~empty;
    always_comb begin
        m_axis.tdata = '0;
        m_axis.tuser = '0;
        if (!empty) begin
            m_axis.tdata = mem[rd_ptr][W-1:0];
            m_axis.tuser = mem[rd_ptr][W+2:W];
        end
    end

    // Storage array: write-only on accepted pushes, no reset needed.
    always_ff @(posedge i_aclk) begin
        if (i_aclken && accept)
            mem[wr_ptr] <= {in_tuser, i_axis_result_tdata};
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge i_aclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (i_aclken) begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // In-flight tracking: saturates at DEPTH on over-issue and at 0 on stray results.
    always_ff @(posedge i_aclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inflight <= '0;
        end else if (i_aclken) begin
            if (i_issue && !accept) begin
                if (inflight != DEPTH_C) inflight <= inflight + 1'b1;
            end else if (accept && !i_issue) begin
                if (inflight != '0) inflight <= inflight - 1'b1;
            end
        end
    end

    // Sticky flags and error; a clear wins over a same-edge set.
    always_ff @(posedge i_aclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sticky_flags <= '0;
            o_buf_err      <= 1'b0;
        end else if (i_aclken) begin
            if (i_sticky_clr) begin
                o_sticky_flags <= '0;
                o_buf_err      <= 1'b0;
            end else begin
                if (accept)  o_sticky_flags <= o_sticky_flags | in_tuser;
                if (err_set) o_buf_err      <= 1'b1;
            end
        end
    end

`ifdef ADDSUB_RESULT_STATS_EN
    // Per-flag event counters indexed like tuser: [2]=invalid, [1]=overflow, [0]=underflow.
    logic [2:0][15:0] stat_cnt;

    // Saturating counters, cleared together with the sticky flags.
    always_ff @(posedge i_aclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stat_cnt <= '0;
        end else if (i_aclken) begin
            for (int k = 0; k < 3; k++) begin
                if (i_sticky_clr)
                    stat_cnt[k] <= '0;
                else if (accept && in_tuser[k] && stat_cnt[k] != 16'hFFFF)
                    stat_cnt[k] <= stat_cnt[k] + 16'd1;
            end
        end
    end

    assign o_cnt_invalid   = stat_cnt[2];
    assign o_cnt_overflow  = stat_cnt[1];
    assign o_cnt_underflow = stat_cnt[0];
`endif
endmodule

// File: doc/ipsxe_floating_point_addsub_result_buf.md
Name: ipsxe_floating_point_addsub_result_buf

Overview:
Downstream companion to the floating-point add/sub core. It captures every result beat (data plus invalid/overflow/underflow flags) into a show-ahead FIFO and re-presents it on a valid/ready master stream, adding backpressure the core itself lacks. It also tracks operations in flight through the core and grants issue credit upstream, so no result is ever dropped. Sticky exception flags and a buffer-overflow error are kept for status readout.

Parameters:
W, 32, result data width (32 or 64).
DEPTH, 16, FIFO entries; power of two, 4..64.
AW, 4, log2(DEPTH); must equal $clog2(DEPTH).

Ports:
i_aclk  in  1  clock.
i_rst_n  in  1  asynchronous active-low reset.
i_aclken  in  1  clock enable; when low all state holds.
i_issue  in  1  pulse: upstream launched one operation into the core this cycle.
o_issue_ready  out  1  credit available; upstream may assert i_issue only when high.
i_axis_result_tdata  in  W  core result.
i_axis_result_tvalid  in  1  core result valid.
i_invalid_op  in  1  core invalid flag, qualified by tvalid.
i_overflow  in  1  core overflow flag, qualified by tvalid.
i_underflow  in  1  core underflow flag, qualified by tvalid.
o_m_axis_tdata  out  W  buffered result.
o_m_axis_tuser  out  3  {invalid_op, overflow, underflow} for the same beat.
o_m_axis_tvalid  out  1  head entry valid.
i_m_axis_tready  in  1  consumer ready.
i_sticky_clr  in  1  clears sticky flags and the error flag.
o_sticky_flags  out  3  OR of all accepted tuser values since the last clear.
o_buf_err  out  1  sticky: a result arrived with no room.

Behaviour:
- Reset: FIFO empty, count=0, inflight=0, o_m_axis_tvalid=0, o_m_axis_tdata=0, o_m_axis_tuser=0, o_sticky_flags=0, o_buf_err=0, o_issue_ready=1. Asynchronous reset mid-stream discards all entries and in-flight tracking.
- All updates occur only on edges where i_aclken=1; when i_aclken=0, outputs hold and no push, pop, or credit change occurs.
- push = i_axis_result_tvalid; pop = o_m_axis_tvalid & i_m_axis_tready.
- A push is accepted if count<DEPTH, or if count==DEPTH and a pop occurs on the same edge.
- A push that is not accepted is dropped and sets o_buf_err. Count and pointers are unchanged.
- Count changes: push only → +1; pop only → −1; both → unchanged.
- Pointers wrap modulo DEPTH.
- Show-ahead: a beat written at edge N drives o_m_axis_tdata/tuser with tvalid=1 after edge N (one-cycle latency from core tvalid to buffer tvalid). Data and tuser are stable while tvalid=1 and tready=0.
- inflight is AW+1 bits.
  - i_issue only → +1; accepted push only → −1; both → unchanged.
  - A push with inflight=0 is not underflowed: inflight saturates at 0 and o_buf_err is set.
- o_issue_ready = (count + inflight) < DEPTH, computed combinationally from registered state.
- i_issue while o_issue_ready=0 is still counted, saturating at DEPTH.
- Sticky flags:
  - o_sticky_flags |= tuser of each accepted push.
  - i_sticky_clr has priority over a same-edge set; a flag asserted on the clear edge is lost.
  - o_buf_err is cleared by i_sticky_clr with the same priority rule.

Optional Feature:
ADDSUB_RESULT_STATS_EN: when defined, adds three 16-bit saturating counters (invalid, overflow, underflow), each incremented on accepted pushes whose corresponding flag is set. Ports o_cnt_invalid, o_cnt_overflow, o_cnt_underflow (out, 16 each) are present. The counters reset to 0, clear on i_sticky_clr, and saturate at 16'hFFFF. When not defined, the counters and ports are absent and behaviour is otherwise identical.

Test Plan:
- Reset then single op: i_issue at cycle 1; core result 32'h40490FDB with flags 0 at cycle 8, tready=1 → tvalid=1 at cycle 9 with tdata 32'h40490FDB, tuser=0; inflight returns to 0; o_issue_ready stays 1.
- Credit exhaustion: DEPTH=16, tready=0, 16 issues → o_issue_ready=0 after the 16th issue. All 16 results are buffered, count=16, o_buf_err=0. Raising tready drains them in order over 16 cycles; o_issue_ready=1 after the first pop.
- Full with simultaneous push/pop: count=16, push and pop on the same edge → push accepted, count stays 16, no error. A push with tready=0 → dropped, o_buf_err=1.
- Sticky flags: results with tuser 3'b100 then 3'b001 → o_sticky_flags=3'b101. i_sticky_clr coincident with a 3'b010 push → o_sticky_flags=0.
- Clock enable: i_aclken=0 for 5 cycles with tvalid/tready/i_issue asserted → no state change. Activity resumes on the first edge with i_aclken=1.
- Reset mid-stream: 5 entries buffered and 3 in flight, pulse i_rst_n low → tvalid=0, o_issue_ready=1, o_sticky_flags=0 immediately (asynchronous).
